decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
- Parametrised successor to the processor decode cycle.
- Splits the 16-bit instruction into fields, reads an internal NREGS x XLEN register file with r0 hardwired to zero, and sign-extends and shifts the immediate.
- Registers the result into an ID/EX pipeline register with valid/ready handshake, stall and flush.
- Sits between fetch (upstream) and execute (downstream); write-back enters through a dedicated write port with its own address.

Parameters:
- XLEN, 16, data/register/PC width; legal range 16..64.
- NREGS, 16, number of architectural registers; legal range 2..16. Register index is 4 bits.
- IMM_SHIFT, 1, left shift applied to the sign-extended immediate; legal range 0..3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- in_ir  in  16  instruction: op=[3:0], rd=[7:4], rs1=[11:8], rs2=[15:12], imm8=[15:8].
- in_pc  in  XLEN  PC of the instruction.
- wb_en  in  1  register write enable.
- wb_addr  in  4  write register index.
- wb_data  in  XLEN  write data.
- flush  in  1  kill the held/incoming instruction.
- out_valid  out  1  ID/EX payload valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  registered PC.
- out_a  out  XLEN  value of rs1.
- out_b  out  XLEN  value of rs2.
- out_op, out_rd, out_rs1, out_rs2  out  4 each  registered fields.
- out_imm  out  XLEN  sign_extend(imm8) << IMM_SHIFT, truncated to XLEN.

Behaviour:
- Reset:
  - Reset is rst==0 at a rising edge.
  - out_valid=0 and every out_* payload=0.
  - All register file entries are cleared to 0.
  - Reset wins over flush, capture and write-back.
  - Reset mid-stall drops the held instruction.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; no bubble when draining).
  - Capture occurs when in_valid && in_ready && !flush: payload loads from in_* and the register file; out_valid=1 next edge.
  - Latency is 1 cycle from in_* to out_*.
- Drain and stall:
  - Drain: out_valid && out_ready && !in_valid -> out_valid=0 next edge; payload holds its last value.
  - Stall: out_valid && !out_ready -> payload and out_valid are frozen bit-exact.
  - A frozen payload is not refreshed by later write-backs; hazard resolution is downstream's job.
- Flush:
  - flush=1 -> out_valid=0 next edge regardless of in_valid/out_ready; no capture that cycle; payload holds.
  - in_ready still follows its equation during flush.
- Register file:
  - Written on the rising edge when wb_en=1, wb_addr!=0 and wb_addr<NREGS; other writes are ignored.
  - Write-back is independent of stall and flush.
  - Reads: index 0 or index >= NREGS returns 0.
  - Same-cycle write and capture of the same register: see Optional Feature.
- Immediate:
  - Take the 8-bit imm8, sign-extend to XLEN, shift left IMM_SHIFT, and drop bits above XLEN-1.
  - Computed combinationally and captured with the payload.
- The op field is passed through undecoded; unknown op values are not flagged.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: on a capture edge, if wb_en writes a nonzero, in-range index equal to rs1 (or rs2), out_a (or out_b) takes wb_data (write-through).
- Undefined: the capture sees the pre-write register value (read-before-write); the new value is visible to captures on later edges.
- Register file contents are identical in both builds.

Test Plan:
- Reset: hold rst=0 for 2 edges after random writes.
  - Expect out_valid=0 and all out_*=0.
  - Then capture ir=0x2160: out_a=0 and out_b=0.
- Basic decode (XLEN=16): write r1=0x0001 and r2=0x0002, then capture ir=0x2160, pc=0x0010 with out_ready=1.
  - Next edge: out_valid=1, out_a=0x0001, out_b=0x0002, out_rd=6, out_rs1=1, out_rs2=2, out_op=0.
  - Also: out_pc=0x0010, out_imm=0x0042.
- Immediate sign: ir=0xF160.
  - XLEN=16, IMM_SHIFT=1: out_imm=0xFFE2.
  - XLEN=32: out_imm=0xFFFFFFE2.
  - IMM_SHIFT=0, XLEN=16: out_imm=0xFFF1.
- Stall/drain: after a capture hold out_ready=0 for 3 cycles while presenting ir=0x3270.
  - in_ready=0 and the payload is unchanged throughout.
  - out_ready=1: in_ready=1 that cycle, new payload (out_rd=7) next edge.
  - Then in_valid=0: out_valid falls.
- r0 and flush: wb_addr=0, wb_data=0xBEEF, then capture ir=0x0060 (rs1=rs2=0).
  - Expect out_a=out_b=0.
  - Assert flush with in_valid=1: out_valid=0 next edge.
- Bypass: r1=0x0001; in the same cycle as capturing ir=0x2160, write wb_addr=1, wb_data=0x00AA.
  - DECODE_WB_BYPASS_EN defined: out_a=0x00AA.
  - Undefined: out_a=0x0001, and the next capture of r1 gives 0x00AA.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - instruction decode stage with register file and ID/EX pipeline register
//
// Splits a 16-bit instruction into fields, reads an NREGS x XLEN register file
// (r0 reads as zero), builds sign_extend(imm8) << IMM_SHIFT and registers the
// result into an ID/EX stage with a valid/ready handshake, stall and flush.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready upstream handshake; in_ir instruction, in_pc its PC
//   wb_en/wb_addr/wb_data  register file write port
//   flush             kill the held/incoming instruction
//   out_valid/out_ready    downstream handshake
//   out_pc, out_a, out_b, out_op, out_rd, out_rs1, out_rs2, out_imm  ID/EX payload
//
// Build option: define DECODE_WB_BYPASS_EN so a capture sees a same-edge
// write-back to rs1/rs2 (write-through); otherwise the capture reads the
// pre-write value.
module decode_stage_pipe #(
  parameter int XLEN      = 16,
  parameter int NREGS     = 16,
  parameter int IMM_SHIFT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_ir,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_en,
  input  logic [3:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_op,
  output logic [3:0]      out_rd,
  output logic [3:0]      out_rs1,
  output logic [3:0]      out_rs2,
  output logic [XLEN-1:0] out_imm
);

  localparam int         IDXW    = $clog2(NREGS);
  localparam logic [4:0] NREGS_L = 5'(NREGS);

  logic [XLEN-1:0] regs [NREGS];

  logic [3:0]      f_op, f_rd, f_rs1, f_rs2;
  logic [7:0]      f_imm8;
  logic [XLEN-1:0] imm_sx, imm_val;
  logic            rs1_ok, rs2_ok, wb_ok, capture;
  logic [XLEN-1:0] rd_a, rd_b, val_a, val_b;

  assign f_op   = in_ir[3:0];
  assign f_rd   = in_ir[7:4];
  assign f_rs1  = in_ir[11:8];
  assign f_rs2  = in_ir[15:12];
  assign f_imm8 = in_ir[15:8];

  assign imm_sx  = {{(XLEN-8){f_imm8[7]}}, f_imm8};
  assign imm_val = imm_sx << IMM_SHIFT;

  // Indices 0 and >= NREGS have no storage behind them and read as zero.
  assign rs1_ok = (f_rs1 != 4'd0) && ({1'b0, f_rs1} < NREGS_L);
  assign rs2_ok = (f_rs2 != 4'd0) && ({1'b0, f_rs2} < NREGS_L);
  assign wb_ok  = wb_en && (wb_addr != 4'd0) && ({1'b0, wb_addr} < NREGS_L);

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (rs1_ok) rd_a = regs[f_rs1[IDXW-1:0]];
    if (rs2_ok) rd_b = regs[f_rs2[IDXW-1:0]];
  end

`ifdef DECODE_WB_BYPASS_EN
  // Write-through: a write landing on this edge is forwarded into the capture.
  assign val_a = (wb_ok && wb_addr == f_rs1) ? wb_data : rd_a;
  assign val_b = (wb_ok && wb_addr == f_rs2) ? wb_data : rd_b;
`else
  assign val_a = rd_a;
  assign val_b = rd_b;
`endif

  // Accepting while draining keeps the stage bubble-free.
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_ok) begin
      regs[wb_addr[IDXW-1:0]] <= wb_data;
    end
  end

  // Payload only loads on capture; drain, stall and flush all leave it untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_op    <= '0;
      out_rd    <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      out_imm   <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (in_ready) begin
        out_valid <= in_valid;
      end
      if (capture) begin
        out_pc  <= in_pc;
        out_a   <= val_a;
        out_b   <= val_b;
        out_op  <= f_op;
        out_rd  <= f_rd;
        out_rs1 <= f_rs1;
        out_rs2 <= f_rs2;
        out_imm <= imm_val;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb/tb_decode_stage_pipe.sv - self-checking bench for decode_stage_pipe
module tb_decode_stage_pipe;

  localparam int XLEN      = 16;
  localparam int NREGS     = 12;
  localparam int IMM_SHIFT = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [15:0]     in_ir = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            wb_en = 1'b0;
  logic [3:0]      wb_addr = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_pc, out_a, out_b, out_imm;
  logic [3:0]      out_op, out_rd, out_rs1, out_rs2;

  decode_stage_pipe #(.XLEN(XLEN), .NREGS(NREGS), .IMM_SHIFT(IMM_SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_a(out_a), .out_b(out_b),
    .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference state: the architectural register file and the expected ID/EX contents.
  logic [XLEN-1:0] m_rf [16];
  logic            m_valid;
  logic [XLEN-1:0] m_pc, m_a, m_b, m_imm;
  logic [3:0]      m_op, m_rd, m_rs1, m_rs2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Immediate as plain signed arithmetic: value * 2^shift, kept modulo 2^xlen.
  function automatic logic [63:0] imm_model(input logic [7:0] b, input int xl, input int sh);
    longint v;
    v = longint'(signed'(b)) * (longint'(1) << sh);
    if (xl < 64) return 64'(v) & ((64'd1 << xl) - 64'd1);
    return 64'(v);
  endfunction

  function automatic logic [XLEN-1:0] rf_read(input logic [3:0] i);
    if (i == 4'd0 || int'(i) >= NREGS) return '0;
    return m_rf[i];
  endfunction

  task automatic model_step();
    logic take, wr;
    if (!rst) begin
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
      m_valid = 1'b0;
      m_pc = '0; m_a = '0; m_b = '0; m_imm = '0;
      m_op = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
    end else begin
      take = in_valid && (!m_valid || out_ready) && !flush;
      wr   = wb_en && wb_addr != 4'd0 && int'(wb_addr) < NREGS;
      if (take) begin
        m_pc  = in_pc;
        m_op  = in_ir[3:0];
        m_rd  = in_ir[7:4];
        m_rs1 = in_ir[11:8];
        m_rs2 = in_ir[15:12];
        m_imm = XLEN'(imm_model(in_ir[15:8], XLEN, IMM_SHIFT));
        m_a   = rf_read(m_rs1);
        m_b   = rf_read(m_rs2);
`ifdef DECODE_WB_BYPASS_EN
        if (wr && wb_addr == m_rs1) m_a = wb_data;
        if (wr && wb_addr == m_rs2) m_b = wb_data;
`endif
      end
      if (flush)     m_valid = 1'b0;
      else if (take) m_valid = 1'b1;
      else           m_valid = m_valid && !out_ready;
      if (wr) m_rf[wb_addr] = wb_data;
    end
  endtask

  // Compare process: every cycle after the first reset, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("in_ready",  64'(in_ready),  64'(!m_valid || out_ready));
      chk("out_pc",    64'(out_pc),    64'(m_pc));
      chk("out_a",     64'(out_a),     64'(m_a));
      chk("out_b",     64'(out_b),     64'(m_b));
      chk("out_op",    64'(out_op),    64'(m_op));
      chk("out_rd",    64'(out_rd),    64'(m_rd));
      chk("out_rs1",   64'(out_rs1),   64'(m_rs1));
      chk("out_rs2",   64'(out_rs2),   64'(m_rs2));
      chk("out_imm",   64'(out_imm),   64'(m_imm));
    end
  end

  task automatic drive(input logic r, input logic iv, input logic [15:0] ir,
                       input logic [XLEN-1:0] pc, input logic we, input logic [3:0] wa,
                       input logic [XLEN-1:0] wd, input logic fl, input logic ordy);
    @(negedge clk);
    #1;
    rst = r; in_valid = iv; in_ir = ir; in_pc = pc;
    wb_en = we; wb_addr = wa; wb_data = wd; flush = fl; out_ready = ordy;
    @(posedge clk);
    model_step();
    #2;
  endtask

  initial begin
    chk("model_imm_f1_x16_s1", imm_model(8'hF1, 16, 1), 64'hFFE2);
    chk("model_imm_f1_x32_s1", imm_model(8'hF1, 32, 1), 64'hFFFF_FFE2);
    chk("model_imm_f1_x16_s0", imm_model(8'hF1, 16, 0), 64'hFFF1);
    chk("model_imm_21_x16_s1", imm_model(8'h21, 16, 1), 64'h0042);

    drive(0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;

    // Reset after random writes and an in-flight capture.
    for (int i = 0; i < 4; i++)
      drive(1, 1, 16'h2160, XLEN'($urandom), 1, 4'($urandom), XLEN'($urandom), 0, 0);
    drive(0, 1, 16'h2160, 16'h5, 1, 1, 16'h1234, 0, 0);
    drive(0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_a",     64'(out_a), 0);
    chk("rst_out_imm",   64'(out_imm), 0);
    chk("rst_out_pc",    64'(out_pc), 0);
    drive(1, 1, 16'h2160, 16'h0, 0, 0, 0, 0, 1);
    chk("rst_rf_a", 64'(out_a), 0);
    chk("rst_rf_b", 64'(out_b), 0);

    // Basic decode.
    drive(1, 0, 16'h0, 0, 1, 1, 16'h0001, 0, 1);
    drive(1, 0, 16'h0, 0, 1, 2, 16'h0002, 0, 1);
    drive(1, 1, 16'h2160, 16'h0010, 0, 0, 0, 0, 1);
    chk("dec_valid", 64'(out_valid), 1);
    chk("dec_a",     64'(out_a), 64'h1);
    chk("dec_b",     64'(out_b), 64'h2);
    chk("dec_rd",    64'(out_rd), 6);
    chk("dec_rs1",   64'(out_rs1), 1);
    chk("dec_rs2",   64'(out_rs2), 2);
    chk("dec_op",    64'(out_op), 0);
    chk("dec_pc",    64'(out_pc), 64'h10);
    chk("dec_imm",   64'(out_imm), 64'h42);

    // Negative immediate; rs2=15 is beyond NREGS and reads zero.
    drive(1, 1, 16'hF160, 16'h0012, 0, 0, 0, 0, 1);
    chk("neg_imm", 64'(out_imm), 64'hFFE2);
    chk("oob_b",   64'(out_b), 0);

    // Stall for three cycles, then drain-accept and empty.
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 16'h3270, 16'h0020, 0, 0, 0, 0, 0);
      chk("stall_in_ready", 64'(in_ready), 0);
      chk("stall_valid",    64'(out_valid), 1);
      chk("stall_rd",       64'(out_rd), 6);
      chk("stall_imm",      64'(out_imm), 64'hFFE2);
    end
    drive(1, 1, 16'h3270, 16'h0020, 0, 0, 0, 0, 1);
    chk("resume_valid", 64'(out_valid), 1);
    chk("resume_rd",    64'(out_rd), 7);
    drive(1, 0, 16'h0, 0, 0, 0, 0, 0, 1);
    chk("drain_valid", 64'(out_valid), 0);
    chk("drain_rd",    64'(out_rd), 7);

    // r0 write ignored; flush kills the incoming instruction.
    drive(1, 0, 16'h0, 0, 1, 0, 16'hBEEF, 0, 1);
    drive(1, 1, 16'h0060, 16'h0030, 0, 0, 0, 0, 1);
    chk("r0_a", 64'(out_a), 0);
    chk("r0_b", 64'(out_b), 0);
    drive(1, 1, 16'h2160, 16'h0032, 0, 0, 0, 1, 1);
    chk("flush_valid", 64'(out_valid), 0);
    chk("flush_pc",    64'(out_pc), 64'h30);

    // Same-edge write-back and capture of r1.
    drive(1, 1, 16'h2160, 16'h0040, 1, 1, 16'h00AA, 0, 1);
`ifdef DECODE_WB_BYPASS_EN
    chk("bypass_a", 64'(out_a), 64'hAA);
`else
    chk("bypass_a", 64'(out_a), 64'h1);
`endif
    drive(1, 1, 16'h2160, 16'h0042, 0, 0, 0, 0, 1);
    chk("after_wb_a", 64'(out_a), 64'hAA);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom % 64) != 0, ($urandom % 10) < 7, 16'($urandom), XLEN'($urandom),
            ($urandom % 2) == 0, 4'($urandom), XLEN'($urandom),
            ($urandom % 10) == 0, ($urandom % 10) < 6);
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
